// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-control bundle: stage status in, latch enables/flushes/halt out.
// The master side is the datapath; the slave side is hazard_ctrl.
interface hazard_ctrl_if;
  logic       ihit;
  logic       dhit;
  logic       exmem_dREN;
  logic       exmem_dWEN;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       ifid_uses_rt;
  logic       idex_dREN;
  logic       idex_regWrite;
  logic [4:0] idex_wsel;
  logic       ex_redirect;
  logic       idex_halt;
  logic       memwb_halt;

  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       memwb_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       halt;

  modport master (
    output ihit, dhit, exmem_dREN, exmem_dWEN, ifid_rs, ifid_rt, ifid_uses_rt,
           idex_dREN, idex_regWrite, idex_wsel, ex_redirect, idex_halt, memwb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt
  );

  modport slave (
    input  ihit, dhit, exmem_dREN, exmem_dWEN, ifid_rs, ifid_rt, ifid_uses_rt,
           idex_dREN, idex_regWrite, idex_wsel, ex_redirect, idex_halt, memwb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard control: zero-latency combinational enables/flushes; nothing moves while
// fetch or data memory waits (advance low). HAZARD_PERF_EN adds saturating stall/flush counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  hazard_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t r_state, w_next;
  logic   r_dseen;
  logic   w_dmem_req, w_advance, w_load_use;
  logic   w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
  logic   w_ifid_flush, w_idex_flush, w_halt;

  assign w_dmem_req = bus.exmem_dREN | bus.exmem_dWEN;
  // dseen keeps a completed data access counted while the fetch is still outstanding
  assign w_advance  = bus.ihit & (~w_dmem_req | bus.dhit | r_dseen);
  assign w_load_use = bus.idex_dREN & bus.idex_regWrite & (bus.idex_wsel != 5'd0) &
                      ((bus.idex_wsel == bus.ifid_rs) |
                       (bus.ifid_uses_rt & (bus.idex_wsel == bus.ifid_rt)));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_RUN;
      r_dseen <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_advance)
        r_dseen <= 1'b0;
      else if (w_dmem_req && bus.dhit)
        r_dseen <= 1'b1;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_pc_en      = 1'b0;
    w_ifid_en    = 1'b0;
    w_idex_en    = 1'b0;
    w_exmem_en   = 1'b0;
    w_memwb_en   = 1'b0;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_halt       = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_advance) begin
          w_idex_en  = 1'b1;
          w_exmem_en = 1'b1;
          w_memwb_en = 1'b1;
          if (bus.ex_redirect) begin
            w_pc_en      = 1'b1;
            w_ifid_en    = 1'b1;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
          end else if (w_load_use) begin
            w_idex_flush = 1'b1;
          end else begin
            w_pc_en   = 1'b1;
            w_ifid_en = 1'b1;
          end
          if (bus.idex_halt && !bus.ex_redirect)
            w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_advance) begin
          w_ifid_en    = 1'b1;
          w_idex_en    = 1'b1;
          w_exmem_en   = 1'b1;
          w_memwb_en   = 1'b1;
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
        end
      end
      ST_HALTED: w_halt = 1'b1;
      default:   w_next = ST_RUN;
    endcase
    if (bus.memwb_halt)
      w_next = ST_HALTED;
  end

  // Outputs are held low for the whole time reset is asserted, not just at the edge.
  assign bus.pc_en      = nRST & w_pc_en;
  assign bus.ifid_en    = nRST & w_ifid_en;
  assign bus.idex_en    = nRST & w_idex_en;
  assign bus.exmem_en   = nRST & w_exmem_en;
  assign bus.memwb_en   = nRST & w_memwb_en;
  assign bus.ifid_flush = nRST & w_ifid_flush;
  assign bus.idex_flush = nRST & w_idex_flush;
  assign bus.halt       = nRST & w_halt;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_stall_evt, w_flush_evt;

  assign w_stall_evt = (r_state == ST_RUN) & w_advance & ~bus.ex_redirect & w_load_use;
  assign w_flush_evt = (r_state == ST_RUN) & w_advance & bus.ex_redirect;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_evt && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: outputs packed as {pc,ifid,idex,exmem,memwb,ifid_fl,idex_fl,halt}.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  hazard_ctrl_if bus();

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.CNT_W(32)) dut (
    .CLK       (clk),
    .nRST      (nrst),
`ifdef HAZARD_PERF_EN
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
`endif
    .bus       (bus)
  );

  localparam logic [7:0] IDLE      = 8'b0000_0000;
  localparam logic [7:0] RUN_ALL   = 8'b1111_1000;
  localparam logic [7:0] BUBBLE    = 8'b0011_1010;
  localparam logic [7:0] SQUASH    = 8'b1111_1110;
  localparam logic [7:0] DRAIN_ADV = 8'b0111_1110;
  localparam logic [7:0] HALTED    = 8'b0000_0001;

  int n_run  = 0;
  int n_fail = 0;

  function automatic logic [7:0] obs();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush, bus.halt};
  endfunction

  task automatic clear_in();
    bus.ihit = 0; bus.dhit = 0; bus.exmem_dREN = 0; bus.exmem_dWEN = 0;
    bus.ifid_rs = 0; bus.ifid_rt = 0; bus.ifid_uses_rt = 0;
    bus.idex_dREN = 0; bus.idex_regWrite = 0; bus.idex_wsel = 0;
    bus.ex_redirect = 0; bus.idex_halt = 0; bus.memwb_halt = 0;
  endtask

  task automatic set_load_use();
    bus.idex_dREN = 1; bus.idex_regWrite = 1; bus.idex_wsel = 5'd8; bus.ifid_rs = 5'd8;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    clear_in();
    next_cycle();
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; clear_in(); bus.ihit = 1;
    #1;
    n_run++; if (obs() !== IDLE) begin n_fail++; $display("FAIL reset_low: got %b want %b", obs(), IDLE); end
    next_cycle();
    n_run++; if (obs() !== IDLE) begin n_fail++; $display("FAIL reset_low_edge: got %b want %b", obs(), IDLE); end
    nrst = 1'b1;
    @(negedge clk);
    n_run++; if (obs() !== RUN_ALL) begin n_fail++; $display("FAIL reset_release: got %b want %b", obs(), RUN_ALL); end
`ifdef HAZARD_PERF_EN
    n_run++; if (stall_cnt !== 0 || flush_cnt !== 0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
`endif
  endtask

  task automatic test_load_use();
    do_reset();
    bus.ihit = 1; set_load_use();
    @(negedge clk);
    n_run++; if (obs() !== BUBBLE) begin n_fail++; $display("FAIL lu_bubble: got %b want %b", obs(), BUBBLE); end
    next_cycle(); bus.idex_dREN = 0;
    @(negedge clk);
    n_run++; if (obs() !== RUN_ALL) begin n_fail++; $display("FAIL lu_after: got %b want %b", obs(), RUN_ALL); end
`ifdef HAZARD_PERF_EN
    n_run++; if (stall_cnt !== 1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
`endif
    next_cycle(); bus.idex_dREN = 1; bus.idex_wsel = 0; bus.ifid_rs = 0;
    @(negedge clk);
    n_run++; if (obs() !== RUN_ALL) begin n_fail++; $display("FAIL lu_wsel0: got %b want %b", obs(), RUN_ALL); end
    next_cycle(); bus.idex_wsel = 5'd8; bus.ifid_rs = 5'd3; bus.ifid_rt = 5'd8; bus.ifid_uses_rt = 0;
    @(negedge clk);
    n_run++; if (obs() !== RUN_ALL) begin n_fail++; $display("FAIL lu_rt_unused: got %b want %b", obs(), RUN_ALL); end
    next_cycle(); bus.ifid_uses_rt = 1;
    @(negedge clk);
    n_run++; if (obs() !== BUBBLE) begin n_fail++; $display("FAIL lu_rt: got %b want %b", obs(), BUBBLE); end
    next_cycle(); bus.idex_regWrite = 0;
    @(negedge clk);
    n_run++; if (obs() !== RUN_ALL) begin n_fail++; $display("FAIL lu_no_regwrite: got %b want %b", obs(), RUN_ALL); end
`ifdef HAZARD_PERF_EN
    n_run++; if (stall_cnt !== 2) begin n_fail++; $display("FAIL lu_stall_cnt2: got %0d want 2", stall_cnt); end
`endif
  endtask

  task automatic test_redirect();
    do_reset();
    bus.ihit = 1; set_load_use(); bus.ex_redirect = 1;
    @(negedge clk);
    n_run++; if (obs() !== SQUASH) begin n_fail++; $display("FAIL redirect_lu: got %b want %b", obs(), SQUASH); end
    next_cycle(); clear_in(); bus.ex_redirect = 1;
    @(negedge clk);
    n_run++; if (obs() !== IDLE) begin n_fail++; $display("FAIL redirect_no_ihit: got %b want %b", obs(), IDLE); end
`ifdef HAZARD_PERF_EN
    n_run++; if (flush_cnt !== 1 || stall_cnt !== 0) begin n_fail++; $display("FAIL redirect_cnt: got %0d/%0d want 1/0", flush_cnt, stall_cnt); end
`endif
    next_cycle(); bus.ihit = 1; bus.idex_halt = 1;
    @(negedge clk);
    n_run++; if (obs() !== SQUASH) begin n_fail++; $display("FAIL redirect_halt: got %b want %b", obs(), SQUASH); end
    next_cycle(); clear_in(); bus.ihit = 1;
    @(negedge clk);
    n_run++; if (obs() !== RUN_ALL) begin n_fail++; $display("FAIL redirect_no_drain: got %b want %b", obs(), RUN_ALL); end
`ifdef HAZARD_PERF_EN
    n_run++; if (flush_cnt !== 2) begin n_fail++; $display("FAIL redirect_cnt2: got %0d want 2", flush_cnt); end
`endif
  endtask

  task automatic test_data_wait();
    do_reset();
    bus.exmem_dREN = 1; bus.dhit = 0; bus.ihit = 1;
    @(negedge clk);
    n_run++; if (obs() !== IDLE) begin n_fail++; $display("FAIL dwait_pending: got %b want %b", obs(), IDLE); end
    next_cycle(); bus.dhit = 1; bus.ihit = 0;
    @(negedge clk);
    n_run++; if (obs() !== IDLE) begin n_fail++; $display("FAIL dwait_ifetch: got %b want %b", obs(), IDLE); end
    next_cycle(); bus.dhit = 0; bus.ihit = 1;
    @(negedge clk);
    n_run++; if (obs() !== RUN_ALL) begin n_fail++; $display("FAIL dseen_advance: got %b want %b", obs(), RUN_ALL); end
    next_cycle();
    @(negedge clk);
    n_run++; if (obs() !== IDLE) begin n_fail++; $display("FAIL dseen_cleared: got %b want %b", obs(), IDLE); end
    next_cycle(); bus.exmem_dREN = 0; bus.exmem_dWEN = 1; bus.dhit = 1;
    @(negedge clk);
    n_run++; if (obs() !== RUN_ALL) begin n_fail++; $display("FAIL dwen_hit: got %b want %b", obs(), RUN_ALL); end
  endtask

  task automatic test_halt_drain();
    do_reset();
    bus.ihit = 1; bus.idex_halt = 1;
    @(negedge clk);
    n_run++; if (obs() !== RUN_ALL) begin n_fail++; $display("FAIL halt_in_ex: got %b want %b", obs(), RUN_ALL); end
    next_cycle(); bus.idex_halt = 0;
    @(negedge clk);
    n_run++; if (obs() !== DRAIN_ADV) begin n_fail++; $display("FAIL drain_adv: got %b want %b", obs(), DRAIN_ADV); end
    next_cycle(); bus.ihit = 0;
    @(negedge clk);
    n_run++; if (obs() !== IDLE) begin n_fail++; $display("FAIL drain_stall: got %b want %b", obs(), IDLE); end
    next_cycle(); bus.ihit = 1; bus.memwb_halt = 1;
    @(negedge clk);
    n_run++; if (obs() !== DRAIN_ADV) begin n_fail++; $display("FAIL drain_last: got %b want %b", obs(), DRAIN_ADV); end
    next_cycle(); bus.memwb_halt = 0; bus.dhit = 1;
    @(negedge clk);
    n_run++; if (obs() !== HALTED) begin n_fail++; $display("FAIL halted: got %b want %b", obs(), HALTED); end
    next_cycle(); set_load_use(); bus.ex_redirect = 1;
    @(negedge clk);
    n_run++; if (obs() !== HALTED) begin n_fail++; $display("FAIL halted_sticky: got %b want %b", obs(), HALTED); end
`ifdef HAZARD_PERF_EN
    next_cycle();
    n_run++; if (flush_cnt !== 0 || stall_cnt !== 0) begin n_fail++; $display("FAIL halted_cnt: got %0d/%0d want 0/0", flush_cnt, stall_cnt); end
`endif
  endtask

  task automatic test_reset_halted();
    do_reset();
    bus.ihit = 0; bus.memwb_halt = 1;
    @(negedge clk);
    n_run++; if (obs() !== IDLE) begin n_fail++; $display("FAIL memwb_halt_run: got %b want %b", obs(), IDLE); end
    next_cycle(); bus.memwb_halt = 0; bus.ihit = 1;
    @(negedge clk);
    n_run++; if (obs() !== HALTED) begin n_fail++; $display("FAIL halt_from_run: got %b want %b", obs(), HALTED); end
    next_cycle();
    nrst = 1'b0;
    #1;
    n_run++; if (obs() !== IDLE) begin n_fail++; $display("FAIL reset_in_halted: got %b want %b", obs(), IDLE); end
    nrst = 1'b1;
    @(negedge clk);
    n_run++; if (obs() !== RUN_ALL) begin n_fail++; $display("FAIL run_after_reset: got %b want %b", obs(), RUN_ALL); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_in();
    test_reset();
    test_load_use();
    test_redirect();
    test_data_wait();
    test_halt_drain();
    test_reset_halted();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
